// File: rtl/fejkon_led_pkg.sv
// Shared types, defaults and helpers for the fejkon front-panel LED status engine.
package fejkon_led_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    STABLE_HI = 2'd1,
    SETTLE    = 2'd2,
    FLAP      = 2'd3
  } led_state_e;

  localparam int unsigned DEF_PORTS           = 4;
  localparam int unsigned DEF_REFERENCE_CLOCK = 50_000_000;
  localparam int unsigned DEF_COOLOFF_MS      = 500;
  localparam int unsigned DEF_BLINK_HZ        = 5;
  localparam int unsigned DEF_LAMP_TEST_MS    = 1000;

  // Milliseconds to clk cycles at the given reference frequency.
  function automatic int unsigned ms_to_cycles(input int unsigned ref_clk,
                                               input int unsigned ms);
    return (ref_clk / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/fejkon_led_chan.sv
// One monitored channel: 2-flop synchroniser, edge detect, cooloff timer and state machine.
// led and flapping are combinational from the state; the top level registers them.
module fejkon_led_chan
  import fejkon_led_pkg::*;
#(
  parameter int unsigned Cooloff = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  input  logic blink,
  output logic led,
  output logic flapping
);

  localparam int unsigned CntW = (Cooloff > 0) ? $clog2(Cooloff + 1) : 1;

  logic [1:0]      sync_q;
  logic            prev_q;
  logic            lvl;
  logic            toggled;
  led_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchroniser plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], level};
      prev_q <= sync_q[1];
    end
  end

  assign lvl     = sync_q[1];
  assign toggled = lvl ^ prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An edge always wins over timer expiry, so a change on the last quiet cycle still flaps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO, STABLE_HI: begin
        if (toggled) begin
          state_d = SETTLE;
          cnt_d   = CntW'(Cooloff);
        end
      end
      SETTLE, FLAP: begin
        if (toggled) begin
          state_d = FLAP;
          cnt_d   = CntW'(Cooloff);
        end else if (cnt_q == '0) begin
          state_d = lvl ? STABLE_HI : STABLE_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign flapping = (state_q == FLAP);
  assign led      = flapping ? blink : lvl;

endmodule

// File: rtl/fejkon_led_status.sv
// Front-panel LED status engine for Ports FC ports plus the transceiver reconfig LED.
// Define FEJKON_LED_LAMP_TEST_EN to light every LED for LampTestMs after reset release.
module fejkon_led_status
  import fejkon_led_pkg::*;
#(
  parameter int unsigned Ports          = DEF_PORTS,
  parameter int unsigned ReferenceClock = DEF_REFERENCE_CLOCK,
  parameter int unsigned CooloffMs      = DEF_COOLOFF_MS,
  parameter int unsigned BlinkHz        = DEF_BLINK_HZ,
  parameter int unsigned LampTestMs     = DEF_LAMP_TEST_MS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [Ports-1:0]   aligned,
  input  logic [Ports-1:0]   active,
  input  logic               reconfig_busy,
  output logic [Ports-1:0]   led_aligned_n,
  output logic [Ports-1:0]   led_active_n,
  output logic               led_busy_n,
  output logic [2*Ports-1:0] flapping
);

  localparam int unsigned Chans      = 2 * Ports;
  localparam int unsigned Cooloff    = ms_to_cycles(ReferenceClock, CooloffMs);
  localparam int unsigned HalfPeriod = ReferenceClock / (2 * BlinkHz);
  localparam int unsigned DivW       = (HalfPeriod > 0) ? $clog2(HalfPeriod + 1) : 1;

  // Reject configurations the counters cannot represent, including an oversized lamp time.
  if (Ports == 0 || Ports > 8 || BlinkHz == 0 || ReferenceClock < 2 * BlinkHz ||
      ((64'(ReferenceClock) / 64'd1000) * 64'(LampTestMs)) > 64'hFFFF_FFFF) begin : g_bad_params
    $error("fejkon_led_status: unsupported parameter set");
  end

  logic [Chans-1:0] chan_level;
  logic [Chans-1:0] chan_led;
  logic [Chans-1:0] chan_flap;
  logic [DivW-1:0]  div_q;
  logic             blink_q;
  logic [1:0]       busy_sync_q;
  logic             lamp_on_c;

  assign chan_level = {active, aligned};

  for (genvar c = 0; c < Chans; c++) begin : g_chan
    fejkon_led_chan #(
      .Cooloff (Cooloff)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .level    (chan_level[c]),
      .blink    (blink_q),
      .led      (chan_led[c]),
      .flapping (chan_flap[c])
    );
  end

  // Shared blink divider: the bit flips every HalfPeriod cycles, first flip HalfPeriod cycles after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= DivW'(HalfPeriod);
      blink_q <= 1'b1;
    end else if (div_q <= DivW'(1)) begin
      div_q   <= DivW'(HalfPeriod);
      blink_q <= ~blink_q;
    end else begin
      div_q <= div_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_sync_q <= 2'b00;
    end else begin
      busy_sync_q <= {busy_sync_q[0], reconfig_busy};
    end
  end

`ifdef FEJKON_LED_LAMP_TEST_EN
  localparam int unsigned LampCycles = ms_to_cycles(ReferenceClock, LampTestMs);
  localparam int unsigned LampW      = (LampCycles > 0) ? $clog2(LampCycles + 1) : 1;

  logic [LampW-1:0] lamp_cnt_q;

  // Reloads on every reset, so a reset during the lamp test restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lamp_cnt_q <= LampW'(LampCycles);
    end else if (lamp_cnt_q != '0) begin
      lamp_cnt_q <= lamp_cnt_q - 1'b1;
    end
  end

  assign lamp_on_c = (lamp_cnt_q != '0);
`else
  assign lamp_on_c = 1'b0;
`endif

  // Output registers; LEDs are active-low, flapping reports FLAP regardless of the lamp test.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_aligned_n <= '1;
      led_active_n  <= '1;
      led_busy_n    <= 1'b1;
      flapping      <= '0;
    end else begin
      if (lamp_on_c) begin
        led_aligned_n <= '0;
        led_active_n  <= '0;
        led_busy_n    <= 1'b0;
      end else begin
        led_aligned_n <= ~chan_led[Ports-1:0];
        led_active_n  <= ~chan_led[Chans-1:Ports];
        led_busy_n    <= ~busy_sync_q[1];
      end
      flapping <= chan_flap;
    end
  end

endmodule

// File: tb/tb_fejkon_led_status.sv
// Self-checking bench for fejkon_led_status: directed scenarios plus random toggling,
// compared every cycle against an episode-based reference model.
module tb_fejkon_led_status;

  localparam int unsigned P  = 4;
  localparam int unsigned CH = 2 * P;
  localparam int unsigned C  = 10;
  localparam int unsigned H  = 10;
`ifdef FEJKON_LED_LAMP_TEST_EN
  localparam int unsigned L  = 20;
`endif

  logic          clk           = 1'b0;
  logic          reset_n       = 1'b0;
  logic [P-1:0]  aligned       = '0;
  logic [P-1:0]  active        = '0;
  logic          reconfig_busy = 1'b0;
  logic [P-1:0]  led_aligned_n;
  logic [P-1:0]  led_active_n;
  logic          led_busy_n;
  logic [CH-1:0] flapping;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  fejkon_led_status #(
    .Ports          (P),
    .ReferenceClock (1000),
    .CooloffMs      (10),
    .BlinkHz        (50),
    .LampTestMs     (20)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .aligned       (aligned),
    .active        (active),
    .reconfig_busy (reconfig_busy),
    .led_aligned_n (led_aligned_n),
    .led_active_n  (led_active_n),
    .led_busy_n    (led_busy_n),
    .flapping      (flapping)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a channel is "unsettled" from its first edge until C+1 quiet cycles after
  // its last edge; with two or more edges in that episode it is flapping and shows blink.
  bit            m_s1[CH], m_s2[CH], m_prev[CH], m_in_ep[CH];
  int            m_edges[CH], m_since[CH];
  bit            m_b1, m_b2;
  int unsigned   n_edges;
  logic [P-1:0]  exp_al_n, exp_ac_n;
  logic          exp_busy_n;
  logic [CH-1:0] exp_flap;

  always @(posedge clk or negedge reset_n) begin : model
    logic [CH-1:0] lin;
    logic [CH-1:0] led;
    bit            blink;
    bit            lamp;
    bit            tgl;
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_prev[c] = 0; m_in_ep[c] = 0;
        m_edges[c] = 0; m_since[c] = 0;
      end
      m_b1 = 0; m_b2 = 0; n_edges = 0;
      exp_al_n = '1; exp_ac_n = '1; exp_busy_n = 1'b1; exp_flap = '0;
    end else begin
      lin   = {active, aligned};
      blink = ((n_edges / H) % 2) == 0;
      lamp  = 1'b0;
`ifdef FEJKON_LED_LAMP_TEST_EN
      lamp  = (n_edges < L);
`endif
      for (int c = 0; c < CH; c++) begin
        exp_flap[c] = m_in_ep[c] && (m_edges[c] >= 2);
        led[c]      = exp_flap[c] ? blink : m_s2[c];
      end
      exp_al_n   = lamp ? '0 : ~led[P-1:0];
      exp_ac_n   = lamp ? '0 : ~led[CH-1:P];
      exp_busy_n = lamp ? 1'b0 : ~m_b2;
      for (int c = 0; c < CH; c++) begin
        tgl = m_s2[c] ^ m_prev[c];
        if (tgl) begin
          if (m_in_ep[c]) m_edges[c]++;
          else begin m_in_ep[c] = 1; m_edges[c] = 1; end
          m_since[c] = 0;
        end else if (m_in_ep[c]) begin
          if (m_since[c] == int'(C)) m_in_ep[c] = 0;
          else m_since[c]++;
        end
        m_prev[c] = m_s2[c];
        m_s2[c]   = m_s1[c];
        m_s1[c]   = lin[c];
      end
      m_b2 = m_b1;
      m_b1 = reconfig_busy;
      n_edges++;
    end
  end

  always @(negedge clk) begin
    if (check_en && reset_n) begin
      check("led_aligned_n", 32'(led_aligned_n), 32'(exp_al_n));
      check("led_active_n",  32'(led_active_n),  32'(exp_ac_n));
      check("led_busy_n",    32'(led_busy_n),    32'(exp_busy_n));
      check("flapping",      32'(flapping),      32'(exp_flap));
    end
  end

  initial begin
    int idx;
    cycles(3);
    check("rst_led_aligned_n", 32'(led_aligned_n), 32'hF);
    check("rst_led_active_n",  32'(led_active_n),  32'hF);
    check("rst_led_busy_n",    32'(led_busy_n),    32'h1);
    check("rst_flapping",      32'(flapping),      32'h0);
    reset_n  = 1'b1;
    check_en = 1'b1;
    cycles(25);

    // Single step on aligned[0]
    aligned[0] = 1'b1;
    cycles(20);

    // active[2] toggled every 3 cycles, 5 times
    for (int i = 0; i < 5; i++) begin
      active[2] = ~active[2];
      cycles(3);
    end
    cycles(1);
    check("flap_active2_set", 32'(flapping[6]), 32'h1);
    cycles(20);
    check("flap_active2_clear", 32'(flapping[6]), 32'h0);
    check("flap_active2_final", 32'(led_active_n[2]), 32'h0);

    // Second edge lands exactly on the counter==0 cycle of SETTLE
    aligned[1] = 1'b1;
    cycles(11);
    aligned[1] = 1'b0;
    cycles(4);
    check("expiry_edge_flap", 32'(flapping[1]), 32'h1);
    cycles(20);

    // Random toggling with short and long holds
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, P - 1));
        aligned[idx] = ~aligned[idx];
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, P - 1));
        active[idx] = ~active[idx];
      end
      if ($urandom_range(0, 9) == 0) reconfig_busy = ~reconfig_busy;
      cycles(int'($urandom_range(1, 4)));
    end
    cycles(25);

    // Reset asserted while active[0] is flapping
    for (int i = 0; i < 4; i++) begin
      active[0] = ~active[0];
      cycles(2);
    end
    check("pre_reset_flap", 32'(flapping[4]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_led_aligned_n", 32'(led_aligned_n), 32'hF);
    check("async_rst_led_active_n",  32'(led_active_n),  32'hF);
    check("async_rst_led_busy_n",    32'(led_busy_n),    32'h1);
    check("async_rst_flapping",      32'(flapping),      32'h0);
    cycles(3);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) aligned = 4'($urandom);
      if ($urandom_range(0, 7) == 0) reconfig_busy = ~reconfig_busy;
      cycles(1);
    end
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
